// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multi-cycle multiply/divide unit.
// Owns the HI/LO architectural registers, starts mult/multu/div/divu from
// the E stage, retires the result after a fixed latency, services
// mthi/mtlo, and raises stall_md when an MD-class instruction in D would
// collide with the busy unit.
// Optional feature: define MUL_DIV_MADD_EN to add SPECIAL2 madd/maddu
// (multiply-accumulate into {hi,lo}).
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] InstrE,
    input  logic        validE,
    input  logic [31:0] rsE,
    input  logic [31:0] rtE,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_MADD  = 6'h00;
    localparam logic [5:0] F_MADDU = 6'h01;

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // True for instructions that occupy the unit for several cycles.
    function automatic logic is_md_start(input logic [31:0] instr);
        logic r;
        r = 1'b0;
        if (instr[31:26] == OP_SPECIAL) begin
            case (instr[5:0])
                F_MULT, F_MULTU, F_DIV, F_DIVU: r = 1'b1;
                default:                        r = 1'b0;
            endcase
        end
`ifdef MUL_DIV_MADD_EN
        else if (instr[31:26] == OP_SPECIAL2) begin
            case (instr[5:0])
                F_MADD, F_MADDU: r = 1'b1;
                default:         r = 1'b0;
            endcase
        end
`endif
        else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // True for any instruction that touches HI/LO or the unit.
    function automatic logic is_md_class(input logic [31:0] instr);
        logic r;
        r = is_md_start(instr);
        if (instr[31:26] == OP_SPECIAL) begin
            case (instr[5:0])
                F_MFHI, F_MTHI, F_MFLO, F_MTLO: r = 1'b1;
                default:                        r = r;
            endcase
        end else begin
            r = r;
        end
        return r;
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;
    logic        pend_wr_r;

    logic        start_s;
    logic        is_mthi_s;
    logic        is_mtlo_s;
    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic [31:0] divisor_s;
    logic signed [32:0] sdividend_s;
    logic signed [32:0] sdivisor_s;
    logic signed [32:0] squot_s;
    logic signed [32:0] srem_s;
    logic [31:0] uquot_s;
    logic [31:0] urem_s;
    logic [63:0] result_s;
    logic        result_wr_s;
    logic [3:0]  lat_s;

    // Decode of E-stage start and HI/LO move requests.
    always_comb begin
        start_s   = validE & is_md_start(InstrE) & (state_r == IDLE);
        is_mthi_s = (InstrE[31:26] == OP_SPECIAL) && (InstrE[5:0] == F_MTHI);
        is_mtlo_s = (InstrE[31:26] == OP_SPECIAL) && (InstrE[5:0] == F_MTLO);
    end

    // Hold D while the unit is busy or about to become busy.
    always_comb begin
        stall_md = is_md_class(InstrD) & (busy | start_s);
    end

    // Arithmetic datapath; the divisor is forced to 1 on zero so the
    // dividers never see /0 (that result is discarded at retire anyway).
    always_comb begin
        sprod_s     = {{32{rsE[31]}}, rsE} * {{32{rtE[31]}}, rtE};
        uprod_s     = {32'd0, rsE} * {32'd0, rtE};
        divisor_s   = (rtE == 32'd0) ? 32'd1 : rtE;
        sdividend_s = {rsE[31], rsE};
        sdivisor_s  = {divisor_s[31], divisor_s};
        squot_s     = sdividend_s / sdivisor_s;
        srem_s      = sdividend_s % sdivisor_s;
        uquot_s     = rsE / divisor_s;
        urem_s      = rsE % divisor_s;
    end

    // Select the pending result, its write enable and its latency.
    always_comb begin
        result_s    = 64'd0;
        result_wr_s = 1'b1;
        lat_s       = 4'd0;
        if (InstrE[31:26] == OP_SPECIAL) begin
            case (InstrE[5:0])
                F_MULT:  begin result_s = sprod_s; lat_s = MULT_LAT; end
                F_MULTU: begin result_s = uprod_s; lat_s = MULT_LAT; end
                F_DIV: begin
                    result_s    = {srem_s[31:0], squot_s[31:0]};
                    result_wr_s = (rtE != 32'd0);
                    lat_s       = DIV_LAT;
                end
                F_DIVU: begin
                    result_s    = {urem_s, uquot_s};
                    result_wr_s = (rtE != 32'd0);
                    lat_s       = DIV_LAT;
                end
                default: begin result_s = 64'd0; lat_s = 4'd0; end
            endcase
        end
`ifdef MUL_DIV_MADD_EN
        else if (InstrE[31:26] == OP_SPECIAL2) begin
            case (InstrE[5:0])
                F_MADD:  begin result_s = {hi, lo} + sprod_s; lat_s = MULT_LAT; end
                F_MADDU: begin result_s = {hi, lo} + uprod_s; lat_s = MULT_LAT; end
                default: begin result_s = 64'd0; lat_s = 4'd0; end
            endcase
        end
`endif
        else begin
            result_s = 64'd0;
            lat_s    = 4'd0;
        end
    end

    // IDLE/BUSY sequencer owning HI/LO, the latency counter and pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        pend_hi_r <= result_s[63:32];
                        pend_lo_r <= result_s[31:0];
                        pend_wr_r <= result_wr_s;
                        cnt_r     <= lat_s;
                        busy      <= 1'b1;
                        state_r   <= BUSY;
                    end else if (validE && is_mthi_s) begin
                        hi <= rsE;
                    end else if (validE && is_mtlo_s) begin
                        lo <= rsE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r == 4'd1) begin
                        if (pend_wr_r) begin
                            hi <= pend_hi_r;
                            lo <= pend_lo_r;
                        end else begin
                            hi <= hi;
                        end
                        cnt_r   <= 4'd0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    cnt_r   <= 4'd0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed plus randomized bench for muldiv_ctrl, checked
// against a cycle-count based reference model of HI/LO, busy and stall_md.
// Honours MUL_DIV_MADD_EN the same way the design does.
module tb_muldiv_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, InstrE, rsE, rtE;
    logic        validE;
    logic [31:0] hi, lo;
    logic        busy, stall_md;

    int errors = 0;
    int checks = 0;

    // Reference model state: HI/LO, pending result and the cycle it retires.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    bit          m_pwr = 1'b0;
    int          cyc = 0;
    int          retire_at = 0;
    int          stall_cnt;

    // Free-running clock.
    always #5 clk = ~clk;

    muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .InstrE(InstrE),
        .validE(validE), .rsE(rsE), .rtE(rtE), .hi(hi), .lo(lo),
        .busy(busy), .stall_md(stall_md)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'd0, fn};
    endfunction

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MFHI  = 32'h0000_0010;
    localparam logic [31:0] MTHI  = 32'h0000_0011;
    localparam logic [31:0] MFLO  = 32'h0000_0012;
    localparam logic [31:0] MTLO  = 32'h0000_0013;
    localparam logic [31:0] MULT  = 32'h0000_0018;
    localparam logic [31:0] MULTU = 32'h0000_0019;
    localparam logic [31:0] DIV   = 32'h0000_001a;
    localparam logic [31:0] DIVU  = 32'h0000_001b;
    localparam logic [31:0] MADD  = 32'h7000_0000;
    localparam logic [31:0] MADDU = 32'h7000_0001;
    localparam logic [31:0] ADDU  = 32'h0000_0021;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit starts(input logic [31:0] ins);
`ifdef MUL_DIV_MADD_EN
        if (ins == MADD || ins == MADDU) return 1'b1;
`endif
        return (ins == MULT || ins == MULTU || ins == DIV || ins == DIVU);
    endfunction

    function automatic bit md_class(input logic [31:0] ins);
        return starts(ins) || ins == MFHI || ins == MTHI || ins == MFLO || ins == MTLO;
    endfunction

    // One clock: drive inputs, check stall before the edge, update model, check state.
    task automatic cycle(input logic [31:0] d, input logic [31:0] e, input logic v,
                         input logic [31:0] a, input logic [31:0] b, input logic r);
        bit idle, st, wr;
        int n;
        longint sa, sb, q, rm;
        longint unsigned ua, ub, uq, urm;
        logic [63:0] res;
        InstrD = d; InstrE = e; validE = v; rsE = a; rtE = b; reset = r;
        #1;
        idle = !(cyc < retire_at);
        st   = v && starts(e) && idle;
        chk("stall_md", {31'd0, stall_md}, {31'd0, md_class(d) && (!idle || st)});
        @(posedge clk);
        cyc++;
        if (r) begin
            m_hi = 32'd0; m_lo = 32'd0; m_pwr = 1'b0; retire_at = 0;
        end else begin
            if (cyc == retire_at && m_pwr) begin
                m_hi = m_phi; m_lo = m_plo;
            end
            sa = longint'($signed(a)); sb = longint'($signed(b));
            ua = {32'd0, a};           ub = {32'd0, b};
            wr = 1'b1; res = 64'd0; n = MULT_N;
            if (st) begin
                if (e == MULT) res = sa * sb;
                else if (e == MULTU) res = ua * ub;
                else if (e == MADD) res = {m_hi, m_lo} + 64'(sa * sb);
                else if (e == MADDU) res = {m_hi, m_lo} + ua * ub;
                else begin
                    n = DIV_N;
                    if (b == 32'd0) wr = 1'b0;
                    else if (e == DIV) begin
                        q = sa / sb; rm = sa % sb;
                        res = {rm[31:0], q[31:0]};
                    end else begin
                        uq = ua / ub; urm = ua % ub;
                        res = {urm[31:0], uq[31:0]};
                    end
                end
                m_phi = res[63:32]; m_plo = res[31:0]; m_pwr = wr;
                retire_at = cyc + n;
            end else if (v && idle && e == MTHI) m_hi = a;
            else if (v && idle && e == MTLO) m_lo = a;
        end
        #1;
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("busy", {31'd0, busy}, {31'd0, cyc < retire_at});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(NOP, NOP, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] pick_e [11];
        logic [31:0] pick_d [6];
        logic [31:0] e, d, b;
        pick_e = '{NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MADD, MADDU, ADDU};
        pick_d = '{NOP, MFHI, MFLO, MULT, MADD, ADDU};

        // Reset state
        cycle(NOP, NOP, 1'b0, 32'd0, 32'd0, 1'b1);
        cycle(NOP, NOP, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // mult 7 * -3
        cycle(NOP, MULT, 1'b1, 32'd7, -32'sd3, 1'b0);
        idle_cycles(MULT_N);
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFEB);

        // divu 100 / 7, then div -7 / 2
        cycle(NOP, DIVU, 1'b1, 32'd100, 32'd7, 1'b0);
        idle_cycles(DIV_N);
        chk("t2u_lo", lo, 32'd14);
        chk("t2u_hi", hi, 32'd2);
        cycle(NOP, DIV, 1'b1, -32'sd7, 32'd2, 1'b0);
        idle_cycles(DIV_N);
        chk("t2s_lo", lo, 32'hFFFF_FFFD);
        chk("t2s_hi", hi, 32'hFFFF_FFFF);

        // mtlo then divide by zero: HI/LO untouched, full latency
        cycle(NOP, MTLO, 1'b1, 32'h1234, 32'd0, 1'b0);
        cycle(NOP, DIV, 1'b1, 32'd55, 32'd0, 1'b0);
        idle_cycles(DIV_N - 1);
        chk("t3_busy_last", {31'd0, busy}, 32'd1);
        idle_cycles(1);
        chk("t3_lo", lo, 32'h1234);
        chk("t3_hi", hi, 32'hFFFF_FFFF);

        // mult with mflo waiting in D
        stall_cnt = 0;
        cycle(MFLO, MULT, 1'b1, 32'd6, 32'd9, 1'b0);
        for (int i = 0; i < MULT_N + 3; i++) begin
            #1;
            if (stall_md) stall_cnt++;
            cycle(MFLO, NOP, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        chk("t4_stall_len", 32'(stall_cnt), 32'(MULT_N));
        chk("t4_lo", lo, 32'd54);

        // reset on the third busy cycle discards the op
        cycle(NOP, MULTU, 1'b1, 32'd1000, 32'd1000, 1'b0);
        idle_cycles(2);
        cycle(NOP, NOP, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        idle_cycles(MULT_N + 2);
        chk("t5_hi", hi, 32'd0);
        chk("t5_lo", lo, 32'd0);

        // SPECIAL2 madd
        cycle(NOP, MTHI, 1'b1, 32'd0, 32'd0, 1'b0);
        cycle(NOP, MTLO, 1'b1, 32'd10, 32'd0, 1'b0);
        cycle(MADD, MADD, 1'b1, 32'd3, 32'd4, 1'b0);
`ifdef MUL_DIV_MADD_EN
        chk("t6_busy", {31'd0, busy}, 32'd1);
        idle_cycles(MULT_N);
        chk("t6_lo", lo, 32'd22);
        chk("t6_hi", hi, 32'd0);
`else
        chk("t6_busy", {31'd0, busy}, 32'd0);
        idle_cycles(MULT_N);
        chk("t6_lo", lo, 32'd10);
        chk("t6_hi", hi, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            e = pick_e[$urandom_range(10)];
            d = pick_d[$urandom_range(5)];
            if ((cyc < retire_at) && (e == MTHI || e == MTLO)) e = NOP;
            b = $urandom;
            if ($urandom_range(7) == 0) b = 32'd0;
            else if ($urandom_range(2) == 0) b = 32'($urandom_range(15)) - 32'd8;
            cycle(d, e, ($urandom_range(3) != 0), $urandom, b,
                  ($urandom_range(99) == 0));
        end
        idle_cycles(DIV_N + 1);
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
